// File: rtl/agc_loop_ctrl_pkg.sv
// Shared types and constants for the AGC loop sequencer and its window meter.
package agc_loop_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StHold    = 2'd3
    } agc_state_e;

    localparam int unsigned MagW  = 15;
    localparam int unsigned CoefW = 8;

    localparam int unsigned DefWinLog2   = 4;
    localparam int unsigned DefLockCnt   = 4;
    localparam int unsigned DefUnlockCnt = 2;

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// Sample, configuration and control bundle between the AGC sequencer and its driver.
interface agc_loop_ctrl_if;
    import agc_loop_ctrl_pkg::*;

    logic              en;
    logic              hold_req;
    logic              sample_vld;
    logic signed [15:0] y_in;
    logic [15:0]       ref_cfg;
    logic [15:0]       lock_thr;
    logic [CoefW-1:0]  attack_coef;
    logic [CoefW-1:0]  decay_coef;
    logic [CoefW-1:0]  track_coef;
    logic [CoefW-1:0]  a_coef;
    logic [15:0]       reference;
    logic              locked;
    logic [1:0]        state;

    modport master (
        output en, hold_req, sample_vld, y_in, ref_cfg, lock_thr,
               attack_coef, decay_coef, track_coef,
        input  a_coef, reference, locked, state
    );

    modport slave (
        input  en, hold_req, sample_vld, y_in, ref_cfg, lock_thr,
               attack_coef, decay_coef, track_coef,
        output a_coef, reference, locked, state
    );

endinterface

// File: rtl/agc_win_meter.sv
// Windowed magnitude meter: saturating |y|, accumulation over 2^WIN_LOG2 valid samples,
// window-end strobe and the window mean (which includes the closing sample).
module agc_win_meter
    import agc_loop_ctrl_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DefWinLog2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               sample_vld,
    input  logic signed [15:0] y_in,
    output logic               win_end,
    output logic [MagW-1:0]    mean
);

    localparam int unsigned AccW = MagW + WIN_LOG2;

    logic [15:0]         y_u;
    logic [15:0]         y_abs;
    logic [MagW-1:0]     mag;
    logic [AccW-1:0]     acc_sum;
    logic [AccW-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;

    always_comb begin
        y_u   = y_in;
        y_abs = y_u[15] ? (16'd0 - y_u) : y_u;
        // Only -32768 sets bit 15 after negation; clamp it to full scale.
        mag     = y_abs[15] ? {MagW{1'b1}} : y_abs[MagW-1:0];
        acc_sum = acc_q + AccW'(mag);
        win_end = en && sample_vld && (cnt_q == '1);
        mean    = acc_sum[AccW-1 -: MagW];
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en && sample_vld) begin
            acc_d = win_end ? '0 : acc_sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencer: IDLE/ACQUIRE/TRACK/HOLD control of the AGC coefficient and reference
// driven by windowed output-magnitude measurements.
module agc_loop_ctrl
    import agc_loop_ctrl_pkg::*;
#(
    parameter int unsigned WIN_LOG2   = DefWinLog2,
    parameter int unsigned LOCK_CNT   = DefLockCnt,
    parameter int unsigned UNLOCK_CNT = DefUnlockCnt
) (
    input  logic         clk,
    input  logic         rst,
    agc_loop_ctrl_if.slave bus
);

    localparam int unsigned LockW   = $clog2(LOCK_CNT + 1);
    localparam int unsigned UnlockW = $clog2(UNLOCK_CNT + 1);

    agc_state_e         state_q, ret_q;
    logic [LockW-1:0]   lock_cnt_q;
    logic [UnlockW-1:0] unlock_cnt_q;
    logic               last_pos_q;
    logic               locked_q;
    logic [CoefW-1:0]   a_coef_q;
    logic [15:0]        reference_q;

    logic               meter_en;
    logic               win_end;
    logic [MagW-1:0]    mean;
    logic signed [16:0] err;
    logic [16:0]        abs_err;
    logic               in_tol, err_pos, lock_hit, unlock_hit;
    logic [CoefW-1:0]   acq_coef;

    // A hold request or disable on a window-end cycle suppresses the strobe and wipes the window.
    assign meter_en = bus.en && !bus.hold_req && (state_q == StAcquire || state_q == StTrack);

    agc_win_meter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_meter (
        .clk        (clk),
        .rst        (rst),
        .clr        (!meter_en),
        .en         (meter_en),
        .sample_vld (bus.sample_vld),
        .y_in       (bus.y_in),
        .win_end    (win_end),
        .mean       (mean)
    );

    always_comb begin
        err        = signed'({2'b00, mean}) - signed'({2'b00, bus.ref_cfg[15:1]});
        abs_err    = err[16] ? 17'(-err) : 17'(err);
        in_tol     = abs_err <= {1'b0, bus.lock_thr};
        err_pos    = !err[16] && (err != '0);
        acq_coef   = err_pos ? bus.attack_coef : bus.decay_coef;
        lock_hit   = in_tol && (lock_cnt_q == LockW'(LOCK_CNT - 1));
        unlock_hit = !in_tol && (unlock_cnt_q == UnlockW'(UNLOCK_CNT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            last_pos_q   <= 1'b0;
            locked_q     <= 1'b0;
            a_coef_q     <= '0;
            reference_q  <= '0;
        end else if (!bus.en) begin
            state_q      <= StIdle;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            last_pos_q   <= 1'b0;
            locked_q     <= 1'b0;
            a_coef_q     <= '0;
            reference_q  <= bus.ref_cfg;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q      <= StAcquire;
                    lock_cnt_q   <= '0;
                    unlock_cnt_q <= '0;
                    last_pos_q   <= 1'b0;
                    a_coef_q     <= bus.decay_coef;
                    reference_q  <= bus.ref_cfg;
                end
                StAcquire, StTrack: begin
                    if (bus.hold_req) begin
                        ret_q        <= state_q;
                        state_q      <= StHold;
                        lock_cnt_q   <= '0;
                        unlock_cnt_q <= '0;
                        a_coef_q     <= '0;
                    end else if (win_end) begin
                        reference_q <= bus.ref_cfg;
                        last_pos_q  <= err_pos;
                        if (state_q == StAcquire) begin
                            if (lock_hit) begin
                                state_q    <= StTrack;
                                locked_q   <= 1'b1;
                                lock_cnt_q <= '0;
                                a_coef_q   <= bus.track_coef;
                            end else begin
                                lock_cnt_q <= in_tol ? lock_cnt_q + LockW'(1) : '0;
                                a_coef_q   <= acq_coef;
                            end
                        end else begin
                            if (unlock_hit) begin
                                state_q      <= StAcquire;
                                locked_q     <= 1'b0;
                                unlock_cnt_q <= '0;
                                a_coef_q     <= acq_coef;
                            end else begin
                                unlock_cnt_q <= in_tol ? '0 : unlock_cnt_q + UnlockW'(1);
                                a_coef_q     <= bus.track_coef;
                            end
                        end
                    end
                end
                StHold: begin
                    lock_cnt_q   <= '0;
                    unlock_cnt_q <= '0;
                    if (!bus.hold_req) begin
                        state_q <= ret_q;
                        if (ret_q == StTrack) begin
                            a_coef_q <= bus.track_coef;
                        end else begin
                            a_coef_q <= last_pos_q ? bus.attack_coef : bus.decay_coef;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.a_coef    = a_coef_q;
    assign bus.reference = reference_q;
    assign bus.locked    = locked_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed and randomized bench for agc_loop_ctrl against a window-level behavioural model.
module tb_agc_loop_ctrl;

    localparam int Win       = 16;
    localparam int LockNeed  = 4;
    localparam int UnlockNeed = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    agc_loop_ctrl_if bus ();

    agc_loop_ctrl #(
        .WIN_LOG2   (4),
        .LOCK_CNT   (LockNeed),
        .UNLOCK_CNT (UnlockNeed)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_state, m_ret, m_locked, m_coef, m_ref;
    int m_sum, m_n, m_lock, m_unlock, m_lastpos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input int y);
        if (y == -32768) return 32767;
        return (y < 0) ? -y : y;
    endfunction

    task automatic model_clear();
        m_sum = 0; m_n = 0; m_lock = 0; m_unlock = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_ret = 0; m_locked = 0; m_coef = 0; m_ref = 0; m_lastpos = 0;
        model_clear();
    endtask

    task automatic model_step();
        int mean, err, tgt, aerr;
        if (!rst) begin
            model_reset();
        end else if (!bus.en) begin
            m_state = 0; m_locked = 0; m_coef = 0; m_lastpos = 0;
            m_ref = int'(bus.ref_cfg);
            model_clear();
        end else if (m_state == 0) begin
            m_state = 1; m_coef = int'(bus.decay_coef); m_lastpos = 0;
            m_ref = int'(bus.ref_cfg);
            model_clear();
        end else if (m_state == 3) begin
            model_clear();
            if (!bus.hold_req) begin
                m_state = m_ret;
                if (m_ret == 2) m_coef = int'(bus.track_coef);
                else m_coef = m_lastpos ? int'(bus.attack_coef) : int'(bus.decay_coef);
            end
        end else if (bus.hold_req) begin
            m_ret = m_state; m_state = 3; m_coef = 0;
            model_clear();
        end else if (bus.sample_vld) begin
            m_sum += mag_of(int'($signed(bus.y_in)));
            m_n++;
            if (m_n == Win) begin
                mean = m_sum / Win;
                m_sum = 0; m_n = 0;
                m_ref = int'(bus.ref_cfg);
                tgt = int'(bus.ref_cfg) / 2;
                err = mean - tgt;
                aerr = (err < 0) ? -err : err;
                m_lastpos = (err > 0);
                if (m_state == 1) begin
                    m_lock = (aerr <= int'(bus.lock_thr)) ? m_lock + 1 : 0;
                    if (m_lock == LockNeed) begin
                        m_state = 2; m_locked = 1; m_lock = 0; m_coef = int'(bus.track_coef);
                    end else begin
                        m_coef = (err > 0) ? int'(bus.attack_coef) : int'(bus.decay_coef);
                    end
                end else begin
                    m_unlock = (aerr <= int'(bus.lock_thr)) ? 0 : m_unlock + 1;
                    if (m_unlock == UnlockNeed) begin
                        m_state = 1; m_locked = 0; m_unlock = 0;
                        m_coef = (err > 0) ? int'(bus.attack_coef) : int'(bus.decay_coef);
                    end else begin
                        m_coef = int'(bus.track_coef);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), m_state);
        chk("a_coef", 32'(bus.a_coef), m_coef);
        chk("locked", 32'(bus.locked), m_locked);
        chk("reference", 32'(bus.reference), m_ref);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int tgt, off, y;
        bus.en = 1'b0; bus.hold_req = 1'b0; bus.sample_vld = 1'b0; bus.y_in = '0;
        bus.ref_cfg = '0; bus.lock_thr = '0;
        bus.attack_coef = 8'd40; bus.decay_coef = 8'd20; bus.track_coef = 8'd5;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("por_state", 32'(bus.state), 0);
        chk("por_a_coef", 32'(bus.a_coef), 0);
        chk("por_reference", 32'(bus.reference), 0);
        step();
        rst = 1'b1;
        repeat (2) step();

        // Acquire then lock
        bus.ref_cfg = 16'd16000; bus.lock_thr = 16'd256;
        bus.y_in = 16'sd8100; bus.sample_vld = 1'b1; bus.en = 1'b1;
        step();
        repeat (63) step();
        chk("acq_before_lock", 32'(bus.state), 1);
        step();
        chk("lock_state", 32'(bus.state), 2);
        chk("lock_locked", 32'(bus.locked), 1);
        chk("lock_coef", 32'(bus.a_coef), 5);
        chk("lock_reference", 32'(bus.reference), 16000);

        // Loss of lock
        bus.y_in = 16'sd2000;
        repeat (31) step();
        chk("unlock_pending", 32'(bus.state), 2);
        step();
        chk("unlock_state", 32'(bus.state), 1);
        chk("unlock_locked", 32'(bus.locked), 0);
        chk("unlock_coef", 32'(bus.a_coef), 20);
        bus.y_in = 16'sd20000;
        repeat (16) step();
        chk("attack_coef", 32'(bus.a_coef), 40);

        // Relock, then hold mid-window
        bus.y_in = 16'sd8100;
        repeat (64) step();
        chk("relock_state", 32'(bus.state), 2);
        repeat (5) step();
        bus.hold_req = 1'b1;
        step();
        chk("hold_state", 32'(bus.state), 3);
        chk("hold_coef", 32'(bus.a_coef), 0);
        chk("hold_locked", 32'(bus.locked), 1);
        repeat (9) step();
        bus.hold_req = 1'b0;
        step();
        chk("release_state", 32'(bus.state), 2);
        chk("release_coef", 32'(bus.a_coef), 5);
        bus.y_in = 16'sd2000;
        repeat (31) step();
        chk("fresh_window", 32'(bus.state), 2);
        step();
        chk("fresh_unlock", 32'(bus.state), 1);

        // Asynchronous reset mid-operation
        repeat (3) step();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_a_coef", 32'(bus.a_coef), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_reference", 32'(bus.reference), 0);
        bus.en = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("idle_state", 32'(bus.state), 0);
        chk("idle_coef", 32'(bus.a_coef), 0);

        // Saturation with valid gaps: mean must be 32767, tgt 32766 -> err +1 -> attack
        bus.ref_cfg = 16'd65532; bus.lock_thr = 16'd0;
        bus.y_in = -16'sd32768; bus.sample_vld = 1'b1; bus.en = 1'b1;
        step();
        for (int c = 0; c < 32; c++) begin
            bus.sample_vld = (c % 2 == 0);
            step();
            if (c == 29) chk("sat_15_valid", 32'(bus.a_coef), 20);
            if (c == 30) chk("sat_16_valid", 32'(bus.a_coef), 40);
        end

        // Priority: disable + hold on the window-end cycle
        bus.en = 1'b0;
        step();
        bus.ref_cfg = 16'd16000; bus.lock_thr = 16'd256; bus.y_in = 16'sd8100;
        bus.sample_vld = 1'b1; bus.en = 1'b1;
        step();
        repeat (47) step();
        bus.en = 1'b0; bus.hold_req = 1'b1;
        step();
        chk("prio_state", 32'(bus.state), 0);
        chk("prio_locked", 32'(bus.locked), 0);
        bus.en = 1'b1; bus.hold_req = 1'b0; bus.ref_cfg = 16'd16002;
        step();
        chk("reen_state", 32'(bus.state), 1);
        chk("reen_reference", 32'(bus.reference), 16002);
        repeat (48) step();
        chk("prio_no_carry", 32'(bus.state), 1);
        repeat (16) step();
        chk("prio_lock", 32'(bus.state), 2);

        // Randomized traffic
        bus.lock_thr = 16'd300;
        tgt = 8000; off = 0;
        for (int c = 0; c < 1200; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(3))
                    0: bus.ref_cfg = 16'd16000;
                    1: bus.ref_cfg = 16'd30000;
                    2: bus.ref_cfg = 16'd4000;
                    default: bus.ref_cfg = 16'd65535;
                endcase
                bus.lock_thr = 16'(100 + $urandom_range(500));
                bus.attack_coef = 8'($urandom_range(255));
                bus.decay_coef = 8'($urandom_range(255));
                bus.track_coef = 8'($urandom_range(255));
            end
            if (c % 100 == 0) begin
                case ($urandom_range(3))
                    0, 1: off = 0;
                    2: off = 3000;
                    default: off = -3000;
                endcase
            end
            tgt = int'(bus.ref_cfg) / 2;
            y = tgt + off + int'($urandom_range(600)) - 300;
            if (y < 0) y = 0;
            if (y > 32767) y = 32767;
            if ($urandom_range(1) == 1) y = -y;
            if ($urandom_range(99) == 0) y = -32768;
            bus.y_in = 16'(y);
            bus.sample_vld = ($urandom_range(4) != 0);
            bus.en = ($urandom_range(199) != 0);
            if ($urandom_range(59) == 0) bus.hold_req = ~bus.hold_req;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_loop_ctrl.md
Name: agc_loop_ctrl

Overview:
- Sequencer for the feedback AGC datapath. Drives its loop coefficient (a_coef) and its reference level.
- Measures the AGC output magnitude over fixed sample windows and runs an ACQUIRE/TRACK/HOLD state machine.
- Selects a fast coefficient while acquiring, a slow coefficient once locked, and zero while frozen.
- Sits beside the AGC instance in the DSP chain: observes y_out, configures a_coef and reference.

Parameters:
- WIN_LOG2, 4, log2 of samples per measurement window (window = 16 samples).
- LOCK_CNT, 4, consecutive in-tolerance windows required to enter TRACK.
- UNLOCK_CNT, 2, consecutive out-of-tolerance windows required to fall back to ACQUIRE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  loop enable; low forces IDLE.
- hold_req  in  1  freeze request (gain held).
- sample_vld  in  1  y_in qualifier.
- y_in  in  16  signed AGC output sample.
- ref_cfg  in  16  target reference level (unsigned).
- lock_thr  in  16  unsigned tolerance on magnitude error.
- attack_coef  in  8  coefficient used in ACQUIRE when the signal is too loud.
- decay_coef  in  8  coefficient used in ACQUIRE when the signal is too quiet.
- track_coef  in  8  coefficient used in TRACK.
- a_coef  out  8  coefficient to the AGC.
- reference  out  16  reference to the AGC.
- locked  out  1  loop locked flag.
- state  out  2  IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3.

Behaviour:
- Reset is asynchronous, active-low, on clk and rst. Reset values: a_coef=0, reference=0, locked=0, state=IDLE; all counters and the accumulator are 0.
- Magnitude: |y_in|, with -32768 saturated to 32767 (15-bit magnitude).
- Accumulator is (15+WIN_LOG2) bits, unsigned. It adds one magnitude per sample_vld cycle, in ACQUIRE or TRACK only.
- Window end: the 2^WIN_LOG2-th valid sample. On that cycle:
  - mean = accumulator >> WIN_LOG2, computed including the current sample.
  - The accumulator and sample counter clear.
- tgt = ref_cfg >> 1. err = mean - tgt, 17-bit signed. in_tol = |err| <= lock_thr.
- All outputs are registered. A window evaluation updates state, locked and a_coef on the clock edge after the last sample of the window.
- reference: loads ref_cfg in IDLE every cycle, and at each window end otherwise. It never changes mid-window.
- IDLE:
  - a_coef=0, locked=0.
  - en=1 -> ACQUIRE with a fresh window.
- ACQUIRE:
  - a_coef = attack_coef if the last err > 0, else decay_coef. The first window, before any evaluation, uses decay_coef.
  - in_tol increments lock_cnt; otherwise lock_cnt clears.
  - lock_cnt reaching LOCK_CNT -> TRACK, locked=1, lock_cnt cleared.
- TRACK:
  - a_coef = track_coef.
  - !in_tol increments unlock_cnt; in_tol clears it.
  - unlock_cnt reaching UNLOCK_CNT -> ACQUIRE, locked=0, unlock_cnt cleared.
- HOLD:
  - Entered from ACQUIRE or TRACK when hold_req=1. The return state is saved.
  - a_coef=0; locked keeps its value.
  - Accumulator, sample counter and lock/unlock counters clear.
  - hold_req=0 -> saved state with a fresh window.
- Priority within one cycle: en=0 first, then hold_req, then window evaluation.
  - en=0 in any state -> IDLE next cycle, clearing all counters and locked.
  - A window end coinciding with hold_req is discarded.
- ref_cfg, lock_thr and the coefficient inputs are sampled live (quasi-static). A change takes effect at the next evaluation or state entry.

Decomposition:
- Shared package holds:
  - the state encodings (IDLE/ACQUIRE/TRACK/HOLD);
  - magnitude width 15 and coefficient width 8;
  - default WIN_LOG2/LOCK_CNT/UNLOCK_CNT.
- One sub-module, agc_win_meter: magnitude, saturation, windowed accumulation, window-end strobe and mean. Its inputs are clear and enable.
- The FSM and coefficient selection stay in the top.

Test Plan:
- Reset check: assert rst low mid-operation -> same cycle a_coef=0, reference=0, locked=0, state=0; all remain so until en=1.
- Acquire then lock: en=1, ref_cfg=16000 (tgt 8000), lock_thr=256, y_in=8100 on every cycle with sample_vld=1 -> state=TRACK, locked=1, a_coef=track_coef one cycle after the 64th valid sample. reference=16000 throughout.
- Loss of lock: from TRACK, switch y_in to 2000 (err=-6000) -> after 2 windows (32 samples) state=ACQUIRE, locked=0, a_coef=decay_coef. Then y_in=20000 for one window -> a_coef=attack_coef.
- Hold: assert hold_req mid-window in TRACK -> next cycle state=HOLD, a_coef=0, locked stays 1. Release after 10 cycles -> TRACK. The next evaluation occurs only after 16 new valid samples.
- Saturation and valid gaps: y_in=-32768, sample_vld toggling 1/0 -> mean=32767. The window closes after 16 valid samples (32 cycles); invalid cycles do not advance the counter.
- Priority: en=0 on the same cycle as hold_req=1 and a window end -> IDLE, counters cleared, no lock_cnt update. Re-enable -> ACQUIRE, with reference reloaded from ref_cfg.
